// File: rtl/tern_weight_unpacker_if.sv
// ---------------------------------------------------------------------------
// tern_weight_unpacker_if
// Handshake bundle between packed-weight storage, the ternary unpacker and
// the multiplier's weight input.
//
//   byte_in    [7:0]         packed byte of five base-3 trits
//   byte_valid               byte_in holds a byte
//   byte_ready               unpacker takes the byte this cycle
//   w_out      [2*LANES-1:0] LANES signed 2-bit weights, lane 0 oldest
//   w_valid                  w_out holds a full beat
//   w_ready                  consumer takes the beat this cycle
//   w_last                   this beat closes a matrix row
//   err                      sticky flag for an out-of-range byte code
//   err_clr                  synchronous clear for err
//
// master : byte producer / weight consumer side
// slave  : the unpacker itself
// ---------------------------------------------------------------------------
interface tern_weight_unpacker_if #(
   parameter int LANES = 4
);
   logic [7:0]         byte_in;
   logic               byte_valid;
   logic               byte_ready;
   logic [2*LANES-1:0] w_out;
   logic               w_valid;
   logic               w_ready;
   logic               w_last;
   logic               err;
   logic               err_clr;

   modport master (
      output byte_in, byte_valid, w_ready, err_clr,
      input  byte_ready, w_out, w_valid, w_last, err
   );

   modport slave (
      input  byte_in, byte_valid, w_ready, err_clr,
      output byte_ready, w_out, w_valid, w_last, err
   );
endinterface

// File: rtl/tern_weight_unpacker.sv
// ---------------------------------------------------------------------------
// tern_weight_unpacker
// Turns a stream of packed ternary bytes (five base-3 digits per byte, d0
// earliest) into beats of LANES two's-complement weights in {-1,0,+1}.
// Each row is ROW_LEN weights long; trits of a byte that run past the end
// of a row are thrown away so the next row starts on a fresh byte.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    tern_weight_unpacker_if.slave (byte in, weight beat out, err)
// ---------------------------------------------------------------------------
module tern_weight_unpacker #(
   parameter int LANES   = 4,
   parameter int ROW_LEN = 4096
) (
   input logic                   clk,
   input logic                   rst_n,
   tern_weight_unpacker_if.slave bus
);
   localparam int DEPTH = LANES + 4;
   localparam int FW    = $clog2(LANES + 5);
   localparam int RW    = $clog2(ROW_LEN + 1);
   localparam int BEATS = ROW_LEN / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int POW3 [5] = '{1, 3, 9, 27, 81};

   logic [1:0]    trits_q [DEPTH];
   logic [1:0]    trits_d [DEPTH];
   logic [FW-1:0] fill_q, fill_d;
   logic [RW-1:0] rowRem_q, rowRem_d;
   logic [BW-1:0] beatCnt_q, beatCnt_d;
   logic          err_q, err_d;
   logic [1:0]    newTrit [5];
   logic          codeBad;
   logic          wValid;
   logic          byteReady;
   logic          pushEn;
   logic          popEn;

   // Handshake status comes only from registered fill, so byte_in never
   // reaches w_out in the same cycle. byte_ready is held low during reset.
   assign wValid    = (fill_q >= FW'(LANES));
   assign byteReady = rst_n && (fill_q <= FW'(LANES - 1));
   assign pushEn    = bus.byte_valid && byteReady;
   assign popEn     = wValid && bus.w_ready;

   assign bus.byte_ready = byteReady;
   assign bus.w_valid    = wValid;
   assign bus.w_last     = wValid && (int'(beatCnt_q) == BEATS - 1);
   assign bus.err        = err_q;

   // Split the incoming byte into five weights. Codes above 242 are not
   // valid base-3 bytes and decode to five zero weights.
   always_comb begin
      int code;
      int digit;
      code    = int'(bus.byte_in);
      codeBad = (code > 242);
      for (int k = 0; k < 5; k++) begin
         digit = (code / POW3[k]) % 3;
         if (codeBad) begin
            newTrit[k] = 2'b00;
         end else begin
            case (digit)
               0:       newTrit[k] = 2'b11;
               1:       newTrit[k] = 2'b00;
               default: newTrit[k] = 2'b01;
            endcase
         end
      end
   end

   // Lane 0 is the oldest trit in the buffer.
   always_comb begin
      bus.w_out = '0;
      for (int i = 0; i < LANES; i++) begin
         bus.w_out[2*i +: 2] = trits_q[i];
      end
   end

   // Next-state: a pop shifts the buffer down by one beat, then a push
   // writes up to five trits right behind whatever is still held.
   always_comb begin
      int rowRemI;
      int pushN;
      int base;
      rowRemI = int'(rowRem_q);
      pushN   = (rowRemI < 5) ? rowRemI : 5;
      base    = int'(fill_q);
      for (int j = 0; j < DEPTH; j++) begin
         trits_d[j] = trits_q[j];
      end
      if (popEn) begin
         base = base - LANES;
         for (int j = 0; j < DEPTH; j++) begin
            trits_d[j] = (j + LANES < DEPTH) ? trits_q[(j + LANES) % DEPTH] : 2'b00;
         end
      end
      if (pushEn) begin
         for (int j = 0; j < DEPTH; j++) begin
            for (int k = 0; k < 5; k++) begin
               if (k < pushN && j == base + k) begin
                  trits_d[j] = newTrit[k];
               end
            end
         end
      end
      fill_d = FW'(pushEn ? base + pushN : base);

      rowRem_d = rowRem_q;
      if (pushEn) begin
         rowRem_d = (rowRemI <= 5) ? RW'(ROW_LEN) : RW'(rowRemI - 5);
      end

      beatCnt_d = beatCnt_q;
      if (popEn) begin
         beatCnt_d = (int'(beatCnt_q) == BEATS - 1) ? '0 : beatCnt_q + BW'(1);
      end

      // A fresh bad byte wins over a simultaneous clear.
      err_d = err_q;
      if (pushEn && codeBad) begin
         err_d = 1'b1;
      end else if (bus.err_clr) begin
         err_d = 1'b0;
      end
   end

   // State registers; reset discards any partially assembled row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < DEPTH; j++) begin
            trits_q[j] <= 2'b00;
         end
         fill_q    <= '0;
         rowRem_q  <= RW'(ROW_LEN);
         beatCnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         for (int j = 0; j < DEPTH; j++) begin
            trits_q[j] <= trits_d[j];
         end
         fill_q    <= fill_d;
         rowRem_q  <= rowRem_d;
         beatCnt_q <= beatCnt_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: tb/tb_tern_weight_unpacker.sv
// ---------------------------------------------------------------------------
// tb_tern_weight_unpacker
// Scoreboard bench for tern_weight_unpacker with LANES=4, ROW_LEN=8.
// A reference model turns every accepted byte into weights with plain
// base-3 arithmetic and queues the expected beats; a monitor compares the
// DUT against the front of that queue on every falling edge.
// ---------------------------------------------------------------------------
module tb_tern_weight_unpacker;
   localparam int LANES   = 4;
   localparam int ROW_LEN = 8;

   typedef struct {
      logic [2*LANES-1:0] wout;
      logic               last;
   } beat_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   int    tritQ[$];
   beat_t expQ[$];
   beat_t beatLog[$];
   int    rowRem;
   int    beatIdx;
   logic  errM;

   tern_weight_unpacker_if #(.LANES(LANES)) bus ();

   tern_weight_unpacker #(
      .LANES   (LANES),
      .ROW_LEN (ROW_LEN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: count it, and report it when it does not match.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      tritQ.delete();
      expQ.delete();
      rowRem  = ROW_LEN;
      beatIdx = 0;
      errM    = 1'b0;
   endtask

   // Reference decode: base-3 digits, weight = digit - 1, row truncation,
   // then group every LANES weights into one expected beat.
   task automatic modelAccept(input logic [7:0] b);
      int    code;
      int    n;
      int    pw;
      int    wts[5];
      beat_t bt;
      code = int'(b);
      pw   = 1;
      for (int k = 0; k < 5; k++) begin
         wts[k] = (code > 242) ? 0 : ((code / pw) % 3) - 1;
         pw     = pw * 3;
      end
      n = (rowRem < 5) ? rowRem : 5;
      for (int k = 0; k < n; k++) tritQ.push_back(wts[k]);
      rowRem = rowRem - n;
      if (rowRem == 0) rowRem = ROW_LEN;
      if (code > 242) errM = 1'b1;
      while (tritQ.size() >= LANES) begin
         bt.wout = '0;
         for (int i = 0; i < LANES; i++) bt.wout[2*i +: 2] = 2'(tritQ.pop_front());
         bt.last = (beatIdx == ROW_LEN / LANES - 1);
         beatIdx = (beatIdx + 1) % (ROW_LEN / LANES);
         expQ.push_back(bt);
      end
   endtask

   // Model side: follow every byte the DUT accepts and the err controls.
   initial begin
      resetModel();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            resetModel();
         end else begin
            if (bus.byte_valid && bus.byte_ready) modelAccept(bus.byte_in);
            if (!(bus.byte_valid && bus.byte_ready && bus.byte_in > 8'd242) && bus.err_clr) errM = 1'b0;
         end
      end
   end

   // Monitor side: compare outputs against the scoreboard, retire beats.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            checkOutput("w_valid", 32'(bus.w_valid), 32'(expQ.size() > 0));
            checkOutput("byte_ready", 32'(bus.byte_ready), 32'((tritQ.size() + LANES * expQ.size()) <= LANES - 1));
            checkOutput("err", 32'(bus.err), 32'(errM));
            if (bus.w_valid && expQ.size() > 0) begin
               checkOutput("w_out", 32'(bus.w_out), 32'(expQ[0].wout));
               checkOutput("w_last", 32'(bus.w_last), 32'(expQ[0].last));
               if (bus.w_ready) begin
                  beatLog.push_back('{wout: bus.w_out, last: bus.w_last});
                  void'(expQ.pop_front());
               end
            end
         end
      end
   end

   // Offer one byte and hold it until the unpacker takes it.
   task automatic applyStimulus(input logic [7:0] b, input logic clr);
      int waitCnt;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      bus.err_clr    = clr;
      waitCnt        = 0;
      @(negedge clk);
      while (!bus.byte_ready && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("accept_timeout", 32'(bus.byte_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
      bus.err_clr    = 1'b0;
   endtask

   // Asynchronous reset in the middle of a cycle, then release.
   task automatic doReset();
      bus.byte_valid = 1'b0;
      bus.err_clr    = 1'b0;
      rst_n          = 1'b0;
      #1;
      checkOutput("rst_w_valid", 32'(bus.w_valid), 32'd0);
      checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("rst_w_last", 32'(bus.w_last), 32'd0);
      checkOutput("rst_w_out", 32'(bus.w_out), 32'd0);
      checkOutput("rst_err", 32'(bus.err), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_byte_ready", 32'(bus.byte_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic checkLog(input string name, input int idx, input logic [7:0] wout, input logic last);
      checkOutput({name, "_count"}, 32'(beatLog.size() > idx), 32'd1);
      if (beatLog.size() > idx) begin
         checkOutput({name, "_w_out"}, 32'(beatLog[idx].wout), 32'(wout));
         checkOutput({name, "_w_last"}, 32'(beatLog[idx].last), 32'(last));
      end
   endtask

   // Directed scenarios first, then a long randomized run with a reset in
   // the middle, then a drain.
   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst_n          = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      bus.w_ready    = 1'b0;
      bus.err_clr    = 1'b0;
      @(posedge clk);
      #1;
      doReset();

      // Row of 8: two all-+1 bytes, the second truncated to 3 trits.
      bus.w_ready = 1'b1;
      beatLog.delete();
      applyStimulus(8'd242, 1'b0);
      applyStimulus(8'd242, 1'b0);
      applyStimulus(8'd0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checkLog("row_beat0", 0, 8'h55, 1'b0);
      checkLog("row_beat1", 1, 8'h55, 1'b1);
      checkLog("row_beat2", 2, 8'hFF, 1'b0);

      // Backpressure: held beat, byte_ready low, nothing lost on release.
      doReset();
      bus.w_ready = 1'b0;
      applyStimulus(8'd242, 1'b0);
      bus.byte_in    = 8'd242;
      bus.byte_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("stall_byte_ready", 32'(bus.byte_ready), 32'd0);
         checkOutput("stall_w_out", 32'(bus.w_out), 32'h55);
      end
      @(posedge clk);
      #1;
      bus.w_ready = 1'b1;
      applyStimulus(8'd242, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Mid-row reset: the next row must restart from beat 0.
      applyStimulus(8'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      doReset();
      beatLog.delete();
      bus.w_ready = 1'b1;
      applyStimulus(8'd242, 1'b0);
      applyStimulus(8'd242, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checkLog("restart_beat0", 0, 8'h55, 1'b0);
      checkLog("restart_beat1", 1, 8'h55, 1'b1);

      // Invalid code, clear, and clear colliding with a new error.
      beatLog.delete();
      applyStimulus(8'hFF, 1'b0);
      @(negedge clk);
      checkOutput("err_set", 32'(bus.err), 32'd1);
      checkLog("bad_beat", 0, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      bus.err_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;
      @(negedge clk);
      checkOutput("err_cleared", 32'(bus.err), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(8'hFF, 1'b1);
      @(negedge clk);
      checkOutput("err_set_wins", 32'(bus.err), 32'd1);
      @(posedge clk);
      #1;

      // Randomized traffic with random backpressure and clears.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc == 2000) doReset();
         bus.byte_valid = ($urandom_range(0, 9) < 7);
         bus.byte_in    = 8'($urandom_range(0, 255));
         bus.w_ready    = ($urandom_range(0, 9) < 7);
         bus.err_clr    = ($urandom_range(0, 19) == 0);
         @(posedge clk);
         #1;
      end

      // Drain whatever full beats remain.
      bus.byte_valid = 1'b0;
      bus.err_clr    = 1'b0;
      bus.w_ready    = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("drain_pending_beats", 32'(expQ.size()), 32'd0);
      checkOutput("drain_w_valid", 32'(bus.w_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
